// File: rtl/stream_rr_merge_pkg.sv
// Shared stream definitions: default data width, grant index width and the
// round-robin successor function used by the merge arbiter and future schedulers.
package stream_rr_merge_pkg;

   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned GRANT_W        = 3;

   // Next index after idx in a ring of num entries (wraps to 0).
   function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                  input int unsigned         num);
      if (32'(idx) + 32'd1 >= num) begin
         return '0;
      end else begin
         return idx + GRANT_W'(1);
      end
   endfunction

endpackage

// File: rtl/stream_rr_merge_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_i+1 with wrap-around
// and grants the first requester. Outputs a one-hot grant and its index.
module stream_rr_merge_rr_arbiter
   import stream_rr_merge_pkg::*;
#(
   parameter int unsigned NUM_IN = 2
) (
   input  logic [NUM_IN-1:0]  req_i,
   input  logic [GRANT_W-1:0] last_i,
   output logic [NUM_IN-1:0]  gnt_o,
   output logic [GRANT_W-1:0] idx_o,
   output logic               valid_o
);

   logic [GRANT_W-1:0] cand;

   // Walk the ring once starting after the last winner; first requester wins.
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      gnt_o   = '0;
      cand    = rr_next(last_i, NUM_IN);
      for (int i = 0; i < int'(NUM_IN); i++) begin
         for (int j = 0; j < int'(NUM_IN); j++) begin
            if (!valid_o && (int'(cand) == j) && req_i[j]) begin
               valid_o = 1'b1;
               idx_o   = cand;
            end
         end
         cand = rr_next(cand, NUM_IN);
      end
      for (int j = 0; j < int'(NUM_IN); j++) begin
         gnt_o[j] = valid_o && (int'(idx_o) == j);
      end
   end

endmodule

// File: rtl/stream_rr_merge.sv
// stream_rr_merge: round-robin merge of NUM_IN AXI-Stream inputs onto one
// registered output stage. Define STREAM_MERGE_BURST_EN to hold a grant for up to
// BURST_LEN consecutive beats; otherwise the grant rotates every beat.
module stream_rr_merge
   import stream_rr_merge_pkg::*;
#(
   parameter int unsigned NUM_IN    = 2,
   parameter int unsigned DATA_W    = DATA_W_DEFAULT,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic [NUM_IN*DATA_W-1:0] In_V_TDATA,
   input  logic [NUM_IN-1:0]        In_V_TVALID,
   output logic [NUM_IN-1:0]        In_V_TREADY,
   output logic [DATA_W-1:0]        Output_1_V_TDATA,
   output logic                     Output_1_V_TVALID,
   input  logic                     Output_1_V_TREADY,
   output logic [GRANT_W-1:0]       Grant_id
);

   if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
      $error("stream_rr_merge: NUM_IN must be in 2..8");
   end
   if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
      $error("stream_rr_merge: BURST_LEN must be in 1..255");
   end

   logic [DATA_W-1:0]  data_q;
   logic               valid_q;
   logic [GRANT_W-1:0] gid_q;
   logic [GRANT_W-1:0] last_q;

   logic               load_en;
   logic               offer;
   logic               xfer;
   logic [NUM_IN-1:0]  rr_gnt;
   logic [GRANT_W-1:0] rr_idx;
   logic               rr_any;
   logic [NUM_IN-1:0]  win_gnt;
   logic [GRANT_W-1:0] win_idx;
   logic               win_any;
   logic [DATA_W-1:0]  win_data;

   // The output register can take a new beat when empty or being drained.
   assign load_en = !valid_q || Output_1_V_TREADY;
   assign offer   = load_en && !ap_rst;

   stream_rr_merge_rr_arbiter #(
      .NUM_IN (NUM_IN)
   ) u_rr_arbiter (
      .req_i   (In_V_TVALID),
      .last_i  (last_q),
      .gnt_o   (rr_gnt),
      .idx_o   (rr_idx),
      .valid_o (rr_any)
   );

`ifdef STREAM_MERGE_BURST_EN
   logic              lock_q;
   logic [7:0]        cnt_q;
   logic [NUM_IN-1:0] lock_gnt;
   logic              lock_hold;

   // The locked input is always the last winner; the lock holds only while it stays valid.
   always_comb begin
      for (int j = 0; j < int'(NUM_IN); j++) begin
         lock_gnt[j] = (int'(last_q) == j);
      end
      lock_hold = lock_q && |(In_V_TVALID & lock_gnt);
   end

   // Burst counter: beats taken under the current lock; releases at BURST_LEN or on a gap.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         lock_q <= 1'b0;
         cnt_q  <= 8'd0;
      end else if (load_en) begin
         if (xfer && lock_hold) begin
            if (32'(cnt_q) + 32'd1 >= BURST_LEN) begin
               lock_q <= 1'b0;
               cnt_q  <= 8'd0;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end else if (xfer) begin
            // Fresh round-robin winner starts a new burst.
            lock_q <= (BURST_LEN > 1);
            cnt_q  <= (BURST_LEN > 1) ? 8'd1 : 8'd0;
         end else begin
            lock_q <= 1'b0;
            cnt_q  <= 8'd0;
         end
      end
   end
`endif

   // Winner selection: burst lock overrides the round-robin result when active.
   always_comb begin
      win_gnt = rr_gnt;
      win_idx = rr_idx;
      win_any = rr_any;
`ifdef STREAM_MERGE_BURST_EN
      if (lock_hold) begin
         win_gnt = lock_gnt;
         win_idx = last_q;
         win_any = 1'b1;
      end
`endif
   end

   assign In_V_TREADY = offer ? win_gnt : '0;
   assign xfer        = offer && win_any;

   // Data mux driven by the one-hot grant.
   always_comb begin
      win_data = '0;
      for (int j = 0; j < int'(NUM_IN); j++) begin
         if (win_gnt[j]) begin
            win_data = In_V_TDATA[j*DATA_W +: DATA_W];
         end
      end
   end

   // Output register and round-robin pointer; valid drops when nothing transfers.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         gid_q   <= '0;
         last_q  <= GRANT_W'(NUM_IN - 1);
      end else if (load_en) begin
         valid_q <= xfer;
         if (xfer) begin
            data_q <= win_data;
            gid_q  <= win_idx;
            last_q <= win_idx;
         end
      end
   end

   assign Output_1_V_TDATA  = data_q;
   assign Output_1_V_TVALID = valid_q;
   assign Grant_id          = gid_q;

endmodule

// File: tb/tb_stream_rr_merge.sv
// Self-checking bench for stream_rr_merge (2 inputs): directed vector table,
// burst sequences when STREAM_MERGE_BURST_EN is defined, and a randomized run
// checked against a handshake-level reference model.
module tb_stream_rr_merge;

   localparam int NUM_IN    = 2;
   localparam int DATA_W    = 32;
   localparam int BURST_LEN = 4;

   logic                     ap_clk = 1'b0;
   logic                     ap_rst;
   logic [NUM_IN*DATA_W-1:0] tdata;
   logic [NUM_IN-1:0]        tvalid;
   logic [NUM_IN-1:0]        tready;
   logic [DATA_W-1:0]        odata;
   logic                     ov;
   logic                     ordy;
   logic [2:0]               gid;

   stream_rr_merge #(
      .NUM_IN    (NUM_IN),
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .ap_clk            (ap_clk),
      .ap_rst            (ap_rst),
      .In_V_TDATA        (tdata),
      .In_V_TVALID       (tvalid),
      .In_V_TREADY       (tready),
      .Output_1_V_TDATA  (odata),
      .Output_1_V_TVALID (ov),
      .Output_1_V_TREADY (ordy),
      .Grant_id          (gid)
   );

   always #5 ap_clk = ~ap_clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst;
      logic [1:0]  v;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        rdy;
      logic        ov;
      logic        chk;
      logic [31:0] od;
      logic [2:0]  gid;
      logic [1:0]  trdy;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic rst, input logic [1:0] v, input logic [31:0] d0,
                               input logic [31:0] d1, input logic rdy, input logic exp_ov,
                               input logic chk, input logic [31:0] od, input logic [2:0] g,
                               input logic [1:0] trdy);
      vec_t e;
      e.rst = rst; e.v = v; e.d0 = d0; e.d1 = d1; e.rdy = rdy;
      e.ov = exp_ov; e.chk = chk; e.od = od; e.gid = g; e.trdy = trdy;
      tbl.push_back(e);
   endfunction

   // ---------------- reference model state ----------------
   logic [1:0]  rv;
   logic [31:0] rd[2];
   int          seq[2];
   bit          m_ov;
   logic [31:0] m_data;
   int          m_gid;
   int          m_last;
   int          lock_left;
   int          lock_idx;

   task automatic do_reset();
      #1;
      ap_rst = 1'b1;
      tvalid = '0;
      tdata  = '0;
      ordy   = 1'b1;
      @(posedge ap_clk);
   endtask

   task automatic model_reset();
      m_ov = 1'b0; m_data = '0; m_gid = 0; m_last = NUM_IN - 1;
      lock_left = 0; lock_idx = 0; rv = '0; seq[0] = 0; seq[1] = 0;
   endtask

   // One randomized cycle: drive, compare against the model, advance the model.
   task automatic rand_cycle(input bit drain);
      int         win;
      bit         load;
      logic [1:0] exp_rdy;
      #1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (drain) rv[k] = 1'b0;
         else if (!rv[k]) rv[k] = ($urandom_range(0, 3) != 0);
         rd[k] = {8'(k + 1), 24'(seq[k])};
      end
      ap_rst = 1'b0;
      tvalid = rv;
      tdata  = {rd[1], rd[0]};
      ordy   = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge ap_clk);
      load = !m_ov || ordy;
      win  = -1;
      if (load) begin
`ifdef STREAM_MERGE_BURST_EN
         if (lock_left > 0 && rv[lock_idx]) win = lock_idx;
         else lock_left = 0;
`endif
         for (int s = 1; s <= NUM_IN; s++) begin
            if (win < 0 && rv[(m_last + s) % NUM_IN]) win = (m_last + s) % NUM_IN;
         end
      end
      exp_rdy = (win >= 0) ? 2'(1 << win) : 2'b00;
      check("rand tready", 32'(tready), 32'(exp_rdy));
      check("rand ovalid", 32'(ov), 32'(m_ov));
      if (m_ov) begin
         check("rand tdata", odata, m_data);
         check("rand grant_id", 32'(gid), 32'(m_gid));
      end
      if (load) begin
         m_ov = (win >= 0);
         if (win >= 0) begin
`ifdef STREAM_MERGE_BURST_EN
            if (lock_left > 0) lock_left--;
            else begin
               lock_left = BURST_LEN - 1;
               lock_idx  = win;
            end
`endif
            m_data = rd[win];
            m_gid  = win;
            m_last = win;
            seq[win]++;
            rv[win] = 1'b0;
         end
      end
      @(posedge ap_clk);
   endtask

`ifdef STREAM_MERGE_BURST_EN
   // Input 0 offers n0 beats (0xA0..), input 1 offers 4 beats (0xB0..), sink always ready.
   task automatic burst_seq(input int n0, input string tag);
      int          p0;
      int          p1;
      logic [31:0] outs[$];
      int          cyc[$];
      logic [31:0] exp;
      p0 = 0;
      p1 = 0;
      do_reset();
      for (int c = 0; c < 40 && outs.size() < n0 + 4; c++) begin
         #1;
         ap_rst = 1'b0;
         ordy   = 1'b1;
         tvalid = {p1 < 4, p0 < n0};
         tdata  = {32'hB0 + 32'(p1), 32'hA0 + 32'(p0)};
         @(negedge ap_clk);
         if (ov) begin
            outs.push_back(odata);
            cyc.push_back(c);
         end
         if (tready[0] && tvalid[0]) p0++;
         if (tready[1] && tvalid[1]) p1++;
         @(posedge ap_clk);
      end
      for (int k = 0; k < n0 + 4; k++) begin
         exp = (k < n0) ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k - n0);
         check($sformatf("%s beat%0d", tag, k), (k < outs.size()) ? outs[k] : 32'hDEAD_BEEF, exp);
      end
      if (n0 < 4 && n0 > 0 && cyc.size() > n0) begin
         check($sformatf("%s no gap before B0", tag), 32'(cyc[n0] - cyc[n0-1]), 32'd1);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ap_rst = 1'b1;
      tvalid = '0;
      tdata  = '0;
      ordy   = 1'b1;
      @(posedge ap_clk);

`ifndef STREAM_MERGE_BURST_EN
      // Reset, idle
      add(1, 2'b00, 0, 0, 1, 0, 1, 0, 0, 2'b00);
      add(1, 2'b00, 0, 0, 1, 0, 1, 0, 0, 2'b00);
      add(0, 2'b00, 0, 0, 1, 0, 1, 0, 0, 2'b00);
      // Both inputs valid, sink always ready: strict alternation
      add(0, 2'b11, 32'hA0, 32'hB0, 1, 0, 0, 0, 0, 2'b01);
      add(0, 2'b11, 32'hA1, 32'hB0, 1, 1, 1, 32'hA0, 0, 2'b10);
      add(0, 2'b11, 32'hA1, 32'hB1, 1, 1, 1, 32'hB0, 1, 2'b01);
      add(0, 2'b11, 32'hA2, 32'hB1, 1, 1, 1, 32'hA1, 0, 2'b10);
      add(0, 2'b11, 32'hA2, 32'hB2, 1, 1, 1, 32'hB1, 1, 2'b01);
      add(0, 2'b11, 32'hA3, 32'hB2, 1, 1, 1, 32'hA2, 0, 2'b10);
      add(0, 2'b11, 32'hA3, 32'hB3, 1, 1, 1, 32'hB2, 1, 2'b01);
      add(0, 2'b10, 0, 32'hB3, 1, 1, 1, 32'hA3, 0, 2'b10);
      add(0, 2'b00, 0, 0, 1, 1, 1, 32'hB3, 1, 2'b00);
      add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00);
      // Backpressure for 3 cycles
      add(0, 2'b11, 32'hC0, 32'hD0, 1, 0, 0, 0, 0, 2'b01);
      add(0, 2'b11, 32'hC1, 32'hD0, 0, 1, 1, 32'hC0, 0, 2'b00);
      add(0, 2'b11, 32'hC1, 32'hD0, 0, 1, 1, 32'hC0, 0, 2'b00);
      add(0, 2'b11, 32'hC1, 32'hD0, 0, 1, 1, 32'hC0, 0, 2'b00);
      add(0, 2'b11, 32'hC1, 32'hD0, 1, 1, 1, 32'hC0, 0, 2'b10);
      add(0, 2'b11, 32'hC1, 32'hD1, 1, 1, 1, 32'hD0, 1, 2'b01);
      add(0, 2'b00, 0, 0, 1, 1, 1, 32'hC1, 0, 2'b00);
      add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00);
      // Single active input: no bubbles
      add(0, 2'b10, 0, 32'h10, 1, 0, 0, 0, 0, 2'b10);
      add(0, 2'b10, 0, 32'h11, 1, 1, 1, 32'h10, 1, 2'b10);
      add(0, 2'b10, 0, 32'h12, 1, 1, 1, 32'h11, 1, 2'b10);
      add(0, 2'b10, 0, 32'h13, 1, 1, 1, 32'h12, 1, 2'b10);
      add(0, 2'b00, 0, 0, 1, 1, 1, 32'h13, 1, 2'b00);
      add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00);
      // Reset with 0xB2 pending, then input 0 granted first
      add(0, 2'b10, 0, 32'hB2, 1, 0, 0, 0, 0, 2'b10);
      add(1, 2'b11, 32'hE0, 32'hB3, 0, 1, 1, 32'hB2, 1, 2'b00);
      add(0, 2'b11, 32'hE0, 32'hB3, 1, 0, 1, 0, 0, 2'b01);
      add(0, 2'b00, 0, 0, 1, 1, 1, 32'hE0, 0, 2'b00);
      add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00);

      for (int i = 0; i < tbl.size(); i++) begin
         #1;
         ap_rst = tbl[i].rst;
         tvalid = tbl[i].v;
         tdata  = {tbl[i].d1, tbl[i].d0};
         ordy   = tbl[i].rdy;
         @(negedge ap_clk);
         check($sformatf("vec%0d tready", i), 32'(tready), 32'(tbl[i].trdy));
         check($sformatf("vec%0d ovalid", i), 32'(ov), 32'(tbl[i].ov));
         if (tbl[i].chk) begin
            check($sformatf("vec%0d tdata", i), odata, tbl[i].od);
            check($sformatf("vec%0d grant_id", i), 32'(gid), 32'(tbl[i].gid));
         end
         @(posedge ap_clk);
      end
`else
      burst_seq(4, "burst full");
      burst_seq(2, "burst early release");
`endif

      // Randomized traffic against the reference model, then drain.
      do_reset();
      model_reset();
      for (int c = 0; c < 400; c++) rand_cycle(1'b0);
      for (int c = 0; c < 4; c++) rand_cycle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
